// File: rtl/cu_pkg.sv
// Shared compute-unit types: command lines, buffer status, arbiter sources.
// Arbiter constants used by cu_command_arbiter and cu_command_fifo.
package CU_PKG;

    localparam int CU_ARB_FIFO_DEPTH  = 4;
    localparam int CU_ARB_NUM_CREDITS = 32;

    typedef struct packed {
        logic        valid;
        logic [12:0] command;
        logic [63:0] address;
        logic [11:0] size;
        logic [7:0]  tag;
    } CommandBufferLine;

    typedef struct packed {
        logic empty;
        logic full;
        logic alfull;
    } BufferStatus;

    typedef enum logic [1:0] {
        ARB_READ,
        ARB_PREFETCH,
        ARB_WRITE
    } ArbSource;

    function automatic ArbSource arb_next(ArbSource s);
        unique case (s)
            ARB_READ:     return ARB_PREFETCH;
            ARB_PREFETCH: return ARB_WRITE;
            default:      return ARB_READ;
        endcase
    endfunction

endpackage

// File: rtl/cu_command_fifo.sv
// Per-source command FIFO with status flags and an overflow pulse.
// A pop frees a slot in the same cycle, so a push to a full FIFO is kept.
module cu_command_fifo
    import CU_PKG::*;
#(
    parameter int  DEPTH = CU_ARB_FIFO_DEPTH,
    parameter type T     = CommandBufferLine
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        push,
    input  T            data_in,
    input  logic        pop,
    output T            data_out,
    output BufferStatus status,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign data_out = mem[rd_ptr];

    assign status.empty  = (count == '0);
    assign status.full   = full;
    assign status.alfull = (count >= (AW+1)'(DEPTH - 1));

    // pointers and occupancy
    always_ff @(posedge clock) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // storage; stale entries are unreachable once pointers reset
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/cu_command_arbiter.sv
// Merges read/prefetch/write command streams into one credit-gated port.
// Build option CU_CMD_ARB_WRITE_PRIORITY_EN: strict write priority.
module cu_command_arbiter
    import CU_PKG::*;
#(
    parameter int FIFO_DEPTH  = CU_ARB_FIFO_DEPTH,
    parameter int NUM_CREDITS = CU_ARB_NUM_CREDITS
) (
    input  logic                             clock,
    input  logic                             rstn,
    input  logic                             enabled_in,
    input  CommandBufferLine                 read_command_in,
    input  CommandBufferLine                 prefetch_command_in,
    input  CommandBufferLine                 write_command_in,
    input  logic                             credit_return_in,
    output CommandBufferLine                 command_out,
    output BufferStatus                      read_fifo_status,
    output BufferStatus                      prefetch_fifo_status,
    output BufferStatus                      write_fifo_status,
    output logic [$clog2(NUM_CREDITS+1)-1:0] credits_out,
    output logic [2:0]                       arb_error
);

    localparam int            CW       = $clog2(NUM_CREDITS + 1);
    localparam logic [CW-1:0] MAX_CRED = CW'(NUM_CREDITS);

    CommandBufferLine cmd_in [3];
    CommandBufferLine head   [3];
    BufferStatus      st     [3];
    logic [2:0]       push;
    logic [2:0]       pop;
    logic [2:0]       ovf;
    logic [2:0]       pend;
    ArbSource         last_q;
    ArbSource         grant_src;
    ArbSource         cand;
    logic             grant;
    logic             eligible;
    logic             ret_ok;

    assign cmd_in[0] = read_command_in;
    assign cmd_in[1] = prefetch_command_in;
    assign cmd_in[2] = write_command_in;

    assign read_fifo_status     = st[0];
    assign prefetch_fifo_status = st[1];
    assign write_fifo_status    = st[2];

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        assign push[i] = enabled_in && cmd_in[i].valid;
        assign pend[i] = !st[i].empty;

        cu_command_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (CommandBufferLine)
        ) u_fifo (
            .clock    (clock),
            .rstn     (rstn),
            .push     (push[i]),
            .data_in  (cmd_in[i]),
            .pop      (pop[i]),
            .data_out (head[i]),
            .status   (st[i]),
            .overflow (ovf[i])
        );
    end

    assign eligible = enabled_in && (credits_out != '0) && (|pend);
    assign ret_ok   = credit_return_in && (credits_out != MAX_CRED);

`ifdef CU_CMD_ARB_WRITE_PRIORITY_EN
    ArbSource other;

    // write wins outright; read/prefetch alternate when write is idle
    always_comb begin
        grant     = 1'b0;
        grant_src = ARB_READ;
        cand      = (last_q == ARB_READ) ? ARB_PREFETCH : ARB_READ;
        other     = (cand == ARB_READ) ? ARB_PREFETCH : ARB_READ;
        if (eligible) begin
            grant = 1'b1;
            if (pend[ARB_WRITE])  grant_src = ARB_WRITE;
            else if (pend[cand])  grant_src = cand;
            else                  grant_src = other;
        end
    end
`else
    // three-way round-robin starting after the last granted source
    always_comb begin
        grant     = 1'b0;
        grant_src = ARB_READ;
        cand      = arb_next(last_q);
        for (int i = 0; i < 3; i++) begin
            if (eligible && !grant && pend[cand]) begin
                grant     = 1'b1;
                grant_src = cand;
            end
            cand = arb_next(cand);
        end
    end
`endif

    // pop strobe for the granted FIFO
    always_comb begin
        pop            = '0;
        pop[grant_src] = grant;
    end

    // output register, round-robin pointer, credits and sticky errors
    always_ff @(posedge clock) begin
        if (rstn) begin
            command_out <= '0;
            last_q      <= ARB_WRITE;
            credits_out <= MAX_CRED;
            arb_error   <= '0;
        end else begin
            command_out <= '0;
            if (grant) begin
                command_out       <= head[grant_src];
                command_out.valid <= 1'b1;
`ifdef CU_CMD_ARB_WRITE_PRIORITY_EN
                if (grant_src != ARB_WRITE) last_q <= grant_src;
`else
                last_q <= grant_src;
`endif
            end
            unique case ({grant, ret_ok})
                2'b10:   credits_out <= credits_out - CW'(1);
                2'b01:   credits_out <= credits_out + CW'(1);
                default: ;
            endcase
            if (|ovf) arb_error[0] <= 1'b1;
            if (credit_return_in && !ret_ok) arb_error[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Directed bench for cu_command_arbiter (default parameters).
// Tags carry {source, sequence} so grant order can be checked.
module tb_cu_command_arbiter;
    import CU_PKG::*;

    logic             clock = 1'b0;
    logic             rstn;
    logic             enabled_in;
    CommandBufferLine read_command_in;
    CommandBufferLine prefetch_command_in;
    CommandBufferLine write_command_in;
    logic             credit_return_in;
    CommandBufferLine command_out;
    BufferStatus      read_fifo_status;
    BufferStatus      prefetch_fifo_status;
    BufferStatus      write_fifo_status;
    logic [5:0]       credits_out;
    logic [2:0]       arb_error;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] seen [$];

    always #5 clock = ~clock;

    cu_command_arbiter dut (
        .clock                (clock),
        .rstn                 (rstn),
        .enabled_in           (enabled_in),
        .read_command_in      (read_command_in),
        .prefetch_command_in  (prefetch_command_in),
        .write_command_in     (write_command_in),
        .credit_return_in     (credit_return_in),
        .command_out          (command_out),
        .read_fifo_status     (read_fifo_status),
        .prefetch_fifo_status (prefetch_fifo_status),
        .write_fifo_status    (write_fifo_status),
        .credits_out          (credits_out),
        .arb_error            (arb_error)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic CommandBufferLine mk(logic [7:0] tag);
        CommandBufferLine c;
        c         = '0;
        c.valid   = 1'b1;
        c.command = 13'h00a;
        c.address = {56'h0, tag};
        c.size    = 12'd64;
        c.tag     = tag;
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_rec();
        tick();
        if (command_out.valid) seen.push_back(command_out.tag);
    endtask

    task automatic idle();
        read_command_in     = '0;
        prefetch_command_in = '0;
        write_command_in    = '0;
        credit_return_in    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        enabled_in = 1'b1;
        rstn       = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
    endtask

    function automatic logic [7:0] seen_at(int i);
        if (i < seen.size()) return seen[i];
        return 8'hxx;
    endfunction

    initial begin
        // reset state
        do_reset();
        check("rst_cmd", command_out, '0);
        check("rst_cred", credits_out, 32);
        check("rst_err", arb_error, 0);
        check("rst_rd_st", read_fifo_status, 3'b100);

        // single read: visible two edges after the push
        read_command_in = mk(8'h05);
        tick();
        idle();
        check("lat_n1", command_out.valid, 0);
        tick();
        check("lat_n2", {command_out.valid, command_out.tag}, {1'b1, 8'h05});
        check("lat_cred", credits_out, 31);
        check("lat_pf_st", prefetch_fifo_status.empty, 1);
        check("lat_wr_st", write_fifo_status.empty, 1);

        // three-way round-robin
        do_reset();
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            read_command_in     = mk({2'd0, 6'(i)});
            prefetch_command_in = mk({2'd1, 6'(i)});
            write_command_in    = mk({2'd2, 6'(i)});
            tick_rec();
            if (i == 2) check("rr_wr_alfull", write_fifo_status, 3'b001);
        end
        idle();
        repeat (10) tick_rec();
        check("rr_count", seen.size(), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("rr_%0d", i), seen_at(i), {2'(i % 3), 6'(i / 3)});
        check("rr_ovf", arb_error[0], 0);
        check("rr_cred", credits_out, 23);

        // drain credits, then overflow the read FIFO
        do_reset();
        for (int i = 0; i < 32; i++) begin
            read_command_in = mk(8'h3f);
            tick();
        end
        idle();
        tick();
        tick();
        check("drain_cred", credits_out, 0);
        check("drain_rd_st", read_fifo_status, 3'b100);
        for (int i = 0; i < 5; i++) begin
            read_command_in = mk(8'h10 + 8'(i));
            tick();
        end
        idle();
        check("ovf_rd_st", read_fifo_status, 3'b011);
        check("ovf_err", arb_error[0], 1);
        check("ovf_noout", command_out.valid, 0);

        // return credits: grant plus return leaves credits unchanged
        seen.delete();
        credit_return_in = 1'b1;
        tick();
        check("ret1_cred", credits_out, 1);
        tick_rec();
        check("gr_ret_cred", credits_out, 1);
        repeat (4) tick_rec();
        credit_return_in = 1'b0;
        repeat (3) tick_rec();
        check("ovf_issued", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("ovf_tag_%0d", i), seen_at(i), 8'h10 + 8'(i));
        check("ret_cred", credits_out, 2);

        // two credits, three queued writes
        write_command_in = mk(8'ha0);
        tick();
        check("c2_p1", credits_out, 2);
        write_command_in = mk(8'ha1);
        tick();
        check("c2_p2", credits_out, 1);
        write_command_in = mk(8'ha2);
        tick();
        idle();
        check("c2_p3", credits_out, 0);
        check("c2_out_a1", {command_out.valid, command_out.tag}, {1'b1, 8'ha1});
        tick();
        check("c2_stall_cred", credits_out, 0);
        check("c2_stall_out", command_out.valid, 0);
        check("c2_stall_wr", write_fifo_status.empty, 0);
        credit_return_in = 1'b1;
        tick();
        credit_return_in = 1'b0;
        check("c2_ret_cred", credits_out, 1);
        check("c2_ret_out", command_out.valid, 0);
        tick();
        check("c2_last_cred", credits_out, 0);
        check("c2_out_a2", {command_out.valid, command_out.tag}, {1'b1, 8'ha2});

        // over-return at full credits
        do_reset();
        credit_return_in = 1'b1;
        tick();
        idle();
        check("over_cred", credits_out, 32);
        check("over_err", arb_error, 3'b010);

        // disabled: pushes ignored
        do_reset();
        enabled_in      = 1'b0;
        read_command_in = mk(8'h01);
        tick();
        idle();
        tick();
        check("dis_rd_st", read_fifo_status, 3'b100);
        check("dis_out", command_out, '0);
        enabled_in = 1'b1;

        // simultaneous read + write for two cycles
        do_reset();
        seen.delete();
        for (int i = 0; i < 2; i++) begin
            read_command_in  = mk({2'd0, 6'(i)});
            write_command_in = mk({2'd2, 6'(i)});
            tick_rec();
        end
        idle();
        repeat (6) tick_rec();
        check("rw_count", seen.size(), 4);
`ifdef CU_CMD_ARB_WRITE_PRIORITY_EN
        check("rw_0", seen_at(0), 8'h80);
        check("rw_1", seen_at(1), 8'h81);
        check("rw_2", seen_at(2), 8'h00);
        check("rw_3", seen_at(3), 8'h01);
`else
        check("rw_0", seen_at(0), 8'h00);
        check("rw_1", seen_at(1), 8'h80);
        check("rw_2", seen_at(2), 8'h01);
        check("rw_3", seen_at(3), 8'h81);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
